// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave: oversampled on clk, one MSB-first frame per cs_n window.
// Optional echo of the last accepted frame on sdo via `define SPI_ECHO_EN.
module spi_frame_receiver #(
    parameter int FRAME_BITS  = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs_n,
    output logic [FRAME_BITS-1:0] flattenedMCUout,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  sdo
);

    localparam int CW = $clog2(FRAME_BITS + 1) + 1;
    localparam logic [CW-1:0] CMAX  = '1;
    localparam logic [CW-1:0] CFULL = CW'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CW-1:0]           count;

    logic [SYNC_STAGES-1:0]  sck_sy;
    logic [SYNC_STAGES-1:0]  sdi_sy;
    logic [SYNC_STAGES-1:0]  csn_sy;
    logic                    sck_d;
    logic                    csn_d;
    logic                    sck_s;
    logic                    sdi_s;
    logic                    csn_s;
    logic                    sck_rise;
    logic                    csn_rise;

    assign sck_s    = sck_sy[SYNC_STAGES-1];
    assign sdi_s    = sdi_sy[SYNC_STAGES-1];
    assign csn_s    = csn_sy[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign csn_rise = csn_s & ~csn_d;

    // Synchronise the SPI pins and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sy <= '0;
            sdi_sy <= '0;
            csn_sy <= '1;
            sck_d  <= 1'b0;
            csn_d  <= 1'b1;
        end else begin
            sck_sy <= {sck_sy[SYNC_STAGES-2:0], sck};
            sdi_sy <= {sdi_sy[SYNC_STAGES-2:0], sdi};
            csn_sy <= {csn_sy[SYNC_STAGES-2:0], cs_n};
            sck_d  <= sck_s;
            csn_d  <= csn_s;
        end
    end

    // Frame FSM: shift while selected, judge the bit count when cs_n releases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            shreg           <= '0;
            count           <= '0;
            flattenedMCUout <= '0;
            frame_valid     <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    shreg <= '0;
                    count <= '0;
                    if (!csn_s) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        shreg <= {shreg[FRAME_BITS-2:0], sdi_s};
                        if (count != CMAX) begin
                            count <= count + 1'b1;
                        end
                    end
                    if (csn_rise) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (count == CFULL) begin
                        flattenedMCUout <= shreg;
                        frame_valid     <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_ECHO_EN
    logic [FRAME_BITS-1:0] echo;
    logic                  sck_fall;

    assign sck_fall = ~sck_s & sck_d;

    // Echo the previous accepted frame back to the MCU, MSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo <= '0;
            sdo  <= 1'b0;
        end else if (state == IDLE && !csn_s) begin
            echo <= flattenedMCUout;
            sdo  <= flattenedMCUout[FRAME_BITS-1];
        end else if (state == SHIFT) begin
            if (sck_fall) begin
                echo <= {echo[FRAME_BITS-2:0], 1'b0};
                sdo  <= echo[FRAME_BITS-2];
            end
        end else begin
            echo <= '0;
            sdo  <= 1'b0;
        end
    end
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: directed frames then random ones.
// Expected frames are queued at cs_n release and popped by a monitor.
module tb_spi_frame_receiver;

    localparam int FB   = 48;
    localparam int SS   = 2;
    localparam int SCKH = 5;

    typedef struct {
        bit          is_valid;
        logic [47:0] data;
        int unsigned cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          cs_n = 1'b1;
    logic [FB-1:0] flattenedMCUout;
    logic          frame_valid;
    logic          frame_err;
    logic          sdo;

    int unsigned   cyc = 0;
    int            checks = 0;
    int            fails = 0;
    logic [47:0]   model_out = '0;
    exp_t          sb[$];
    logic [7:0]    sd_exp [6] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

    spi_frame_receiver #(
        .FRAME_BITS (FB),
        .SYNC_STAGES(SS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sck            (sck),
        .sdi            (sdi),
        .cs_n           (cs_n),
        .flattenedMCUout(flattenedMCUout),
        .frame_valid    (frame_valid),
        .frame_err      (frame_err),
        .sdo            (sdo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] echo_exp(input logic [47:0] prev,
                                             input int n);
        logic [63:0] r;
        logic        b;
        r = '0;
        for (int i = 0; i < n; i++) begin
            b = (i < 48) ? prev[47-i] : 1'b0;
`ifndef SPI_ECHO_EN
            b = 1'b0;
`endif
            r = {r[62:0], b};
        end
        return r;
    endfunction

    // Send n bits of 'bits' MSB first; 'late' raises cs_n with the last sck rise
    task automatic send(input logic [63:0] bits, input int n, input bit late);
        logic [63:0] cap;
        logic [47:0] prev;
        exp_t        e;
        cap = '0;
        @(negedge clk);
        cs_n = 1'b0;
        prev = model_out;
        repeat (SCKH) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            sdi = bits[n-1-i];
            repeat (SCKH) @(negedge clk);
            cap = {cap[62:0], sdo};
            sck = 1'b1;
            if (!(late && i == n - 1)) begin
                repeat (SCKH) @(negedge clk);
                sck = 1'b0;
            end
        end
        if (!late || n == 0) repeat (SCKH) @(negedge clk);
        cs_n = 1'b1;
        e.is_valid = (n == 48);
        e.data     = (n == 48) ? bits[47:0] : model_out;
        e.cyc      = cyc + SS + 2;
        sb.push_back(e);
        if (n == 48) model_out = bits[47:0];
        if (n > 0) check("sdo_echo", cap, echo_exp(prev, n));
        if (late && n > 0) begin
            repeat (SCKH) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (frame_valid || frame_err)) begin
            check("exclusive", 64'(frame_valid & frame_err), 64'd0);
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: valid=%b err=%b expected none",
                         frame_valid, frame_err);
            end else begin
                e = sb.pop_front();
                check("frame_valid", 64'(frame_valid), 64'(e.is_valid));
                check("frame_err", 64'(frame_err), 64'(!e.is_valid));
                check("data", 64'(flattenedMCUout), 64'(e.data));
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        checks++;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rb;
        int          n;
        repeat (3) @(negedge clk);
        check("rst_out", 64'(flattenedMCUout), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        check("rst_sdo", 64'(sdo), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        send(64'h5566778899AA, 48, 1'b0);
        repeat (10) @(negedge clk);
        for (int j = 0; j < 6; j++)
            check($sformatf("sd%0d", j),
                  64'(flattenedMCUout[47-8*j -: 8]), 64'(sd_exp[j]));

        send(64'hFF11223344, 40, 1'b0);
        repeat (10) @(negedge clk);
        send({16'h0003, 48'h123456789ABC}, 50, 1'b0);
        repeat (10) @(negedge clk);

        @(negedge clk);
        cs_n = 1'b0;
        repeat (SCKH) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            sdi = 1'b1;
            repeat (SCKH) @(negedge clk);
            sck = 1'b1;
            repeat (SCKH) @(negedge clk);
            sck = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("midrst_out", 64'(flattenedMCUout), 64'd0);
        check("midrst_valid", 64'(frame_valid), 64'd0);
        check("midrst_err", 64'(frame_err), 64'd0);
        check("midrst_sdo", 64'(sdo), 64'd0);
        cs_n = 1'b1;
        sdi  = 1'b0;
        model_out = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send(64'h000000000001, 48, 1'b0);
        repeat (10) @(negedge clk);

        send(64'hAAAAAAAAAAAA, 48, 1'b0);
        repeat (3) @(negedge clk);
        send(64'h555555555555, 48, 1'b0);
        repeat (10) @(negedge clk);
        check("b2b_out", 64'(flattenedMCUout), 64'h555555555555);

        send(64'hC0FFEE123456, 48, 1'b1);
        repeat (10) @(negedge clk);
        send(64'd0, 0, 1'b0);
        repeat (10) @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            rb = {$urandom, $urandom};
            n  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 56) : 48;
            send(rb, n, 1'(k % 5 == 4));
            repeat ($urandom_range(3, 12)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("final_out", 64'(flattenedMCUout), 64'(model_out));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
